moonbase_bus_responder: RTL and testbench

Memory/peripheral responder for the 4-bit moonbase CPU's multiplexed 8-bit bus. It contains:
- the 128x4 program/data RAM,
- 8 nibble-wide output latches,
- a synchronised 4x2-bit input port.

It drives the CPU's ram_in and data_in pins. It owns CPU reset sequencing, so a program can be loaded through a valid/ready port before the CPU runs.

---
 rtl/moonbase_pkg.sv | 23 ++
 rtl/moonbase_ram128x4.sv | 61 ++++++
 rtl/moonbase_bus_responder.sv | 160 ++++++++++++++++
 tb/tb_moonbase_bus_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moonbase_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | moonbase_pkg                                                         |
// | Shared types and bus bit positions for the moonbase bus responder.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package moonbase_pkg;

    localparam int ADDR_W    = 7;
    localparam int NIB_W     = 4;

    localparam int STROBE    = 7;
    localparam int WR_RAM_N  = 5;
    localparam int WR_DATA_N = 4;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/moonbase_ram128x4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | moonbase_ram128x4                                                    |
// | Nibble RAM, one write port muxed loader/bus, one registered read.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module moonbase_ram128x4
    import moonbase_pkg::*;
#(
    parameter int MEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  state_e            state,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [NIB_W-1:0]  load_data,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [NIB_W-1:0]  bus_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [NIB_W-1:0]  rd_data
);

    logic [NIB_W-1:0]  r_mem [MEM_DEPTH];
    logic [NIB_W-1:0]  r_rd_data;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [NIB_W-1:0]  w_data;

    // The loader owns the write port only while the CPU is held in LOAD.
    always_comb begin
        w_we   = bus_we;
        w_addr = bus_addr;
        w_data = bus_data;
        if (state == LOAD) begin
            w_we   = load_we;
            w_addr = load_addr;
            w_data = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/moonbase_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | moonbase_bus_responder                                               |
// | RAM, output latches and input port behind the CPU's muxed bus.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module moonbase_bus_responder
    import moonbase_pkg::*;
#(
    parameter int MEM_DEPTH      = 128,
    parameter int RELEASE_CYCLES = 2,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  bus_in,
    output logic [3:0]  ram_out,
    output logic [1:0]  data_out,
    output logic        cpu_reset,
    input  logic [7:0]  ext_in,
    output logic [31:0] out_port,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [6:0]  load_addr,
    input  logic [3:0]  load_data,
    output logic        load_ready,
    output logic        bus_err
);

    localparam int CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    state_e             r_state, w_next_state;
    logic [CNT_W-1:0]   r_cnt, w_next_cnt;
    logic               r_cpu_reset, r_load_ready, r_bus_err, r_seen_addr;
    logic [ADDR_W-1:0]  r_addr_q;
    logic [1:0]         r_data_out;
    logic [7:0][3:0]    r_out_port;
    logic [7:0]         r_sync [SYNC_STAGES];
    logic [7:0]         w_sync_out;

    logic w_run, w_strobe, w_cycle, w_wr_ram_req, w_wr_data_req, w_bad;
    logic w_bus_wr_ram, w_bus_wr_data, w_load_wr;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            LOAD: begin
                if (!load_en) begin
                    w_next_state = RELEASE;
                    w_next_cnt   = CNT_W'(RELEASE_CYCLES - 1);
                end
            end
            RELEASE: begin
                if (load_en) begin
                    w_next_state = LOAD;
                end else if (r_cnt == '0) begin
                    w_next_state = RUN;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            RUN: begin
                if (load_en) begin
                    w_next_state = LOAD;
                end
            end
            default: w_next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= LOAD;
            r_cnt        <= '0;
            r_cpu_reset  <= 1'b1;
            r_load_ready <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_cpu_reset  <= (w_next_state != RUN);
            r_load_ready <= (w_next_state == LOAD);
        end
    end

    // A write needs a preceding address strobe and exactly one target.
    assign w_run         = (r_state == RUN);
    assign w_strobe      = w_run && bus_in[STROBE];
    assign w_cycle       = w_run && !bus_in[STROBE];
    assign w_wr_ram_req  = w_cycle && !bus_in[WR_RAM_N];
    assign w_wr_data_req = w_cycle && !bus_in[WR_DATA_N];
    assign w_bad         = (w_wr_ram_req || w_wr_data_req) &&
                           (!r_seen_addr || (w_wr_ram_req && w_wr_data_req));
    assign w_bus_wr_ram  = w_wr_ram_req && !w_bad;
    assign w_bus_wr_data = w_wr_data_req && !w_bad;
    assign w_load_wr     = (r_state == LOAD) && load_valid && r_load_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= ext_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr_q    <= '0;
            r_seen_addr <= 1'b0;
            r_data_out  <= '0;
            r_out_port  <= '0;
            r_bus_err   <= 1'b0;
        end else if (w_strobe) begin
            r_addr_q    <= bus_in[ADDR_W-1:0];
            r_seen_addr <= 1'b1;
            r_data_out  <= w_sync_out[{bus_in[1:0], 1'b0} +: 2];
        end else begin
            // Any non-strobe cycle, or leaving RUN, consumes the address phase.
            r_seen_addr <= 1'b0;
            if (w_bad) begin
                r_bus_err <= 1'b1;
            end
            if (w_bus_wr_data) begin
                r_out_port[r_addr_q[2:0]] <= bus_in[NIB_W-1:0];
            end
        end
    end

    moonbase_ram128x4 #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .state     (r_state),
        .load_we   (w_load_wr),
        .load_addr (load_addr),
        .load_data (load_data),
        .bus_we    (w_bus_wr_ram),
        .bus_addr  (r_addr_q),
        .bus_data  (bus_in[NIB_W-1:0]),
        .rd_en     (w_strobe),
        .rd_addr   (bus_in[ADDR_W-1:0]),
        .rd_data   (ram_out)
    );

    assign data_out   = r_data_out;
    assign cpu_reset  = r_cpu_reset;
    assign load_ready = r_load_ready;
    assign bus_err    = r_bus_err;
    assign out_port   = r_out_port;

endmodule
`default_nettype wire

// File: tb/tb_moonbase_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_moonbase_bus_responder                                            |
// | Scenario tasks with a read-result scoreboard for the bus responder.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_moonbase_bus_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  bus_in;
    logic [3:0]  ram_out;
    logic [1:0]  data_out;
    logic        cpu_reset;
    logic [7:0]  ext_in;
    logic [31:0] out_port;
    logic        load_en;
    logic        load_valid;
    logic [6:0]  load_addr;
    logic [3:0]  load_data;
    logic        load_ready;
    logic        bus_err;

    typedef struct packed {
        logic [3:0] ram;
        logic [1:0] data;
    } rd_t;

    rd_t         sb_q[$];
    logic [3:0]  model_mem [128];
    logic [31:0] exp_out;
    logic [7:0]  ext_settled;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    moonbase_bus_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus_in     (bus_in),
        .ram_out    (ram_out),
        .data_out   (data_out),
        .cpu_reset  (cpu_reset),
        .ext_in     (ext_in),
        .out_port   (out_port),
        .load_en    (load_en),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .bus_err    (bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe-read: expectation queued at drive time, checked when data appears.
    task automatic bus_read(input logic [6:0] addr);
        rd_t e;
        logic [7:0] ch;
        ch     = ext_settled >> (2 * addr[1:0]);
        e.ram  = model_mem[addr];
        e.data = ch[1:0];
        sb_q.push_back(e);
        bus_in = {1'b1, addr};
        step();
        bus_in = 8'h30;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL read_scoreboard: queue empty, expected 1 entry");
        end else begin
            e = sb_q.pop_front();
            if (ram_out !== e.ram) begin
                n_fail++;
                $display("FAIL read_ram addr=%0h: got %h expected %h", addr, ram_out, e.ram);
            end
            n_checks++;
            if (data_out !== e.data) begin
                n_fail++;
                $display("FAIL read_data addr=%0h: got %b expected %b", addr, data_out, e.data);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; bus_in = 8'h30; ext_in = 8'hC6; ext_settled = 8'hC6;
        load_en = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
        exp_out = '0;
        repeat (3) step();
        n_checks++;
        if ({cpu_reset, load_ready, bus_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 100", {cpu_reset, load_ready, bus_err});
        end
        n_checks++;
        if ({ram_out, data_out, out_port} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%b/%h expected zeros", ram_out, data_out, out_port);
        end
        reset_n = 1'b1;
        load_en = 1'b1;
        step();
        n_checks++;
        if (load_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready_rise: got rdy=%b rst=%b expected 1 1", load_ready, cpu_reset);
        end
    endtask

    task automatic test_load();
        logic [6:0] addrs [6];
        logic [3:0] vals  [6];
        addrs = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h0A, 7'h05};
        vals  = '{4'h5,  4'h3,  4'hA,  4'hF,  4'h2,  4'h6};
        load_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load_addr = addrs[i];
            load_data = vals[i];
            model_mem[addrs[i]] = vals[i];
            step();
            n_checks++;
            if (load_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_ready_held word %0d: got %b expected 1", i, load_ready);
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic test_release();
        load_en = 1'b0;
        bus_in  = 8'h80;
        step();
        n_checks++;
        if (cpu_reset !== 1'b1 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL release_c1: got rst=%b rdy=%b expected 1 0", cpu_reset, load_ready);
        end
        step();
        n_checks++;
        if (cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL release_c2: got rst=%b expected 1", cpu_reset);
        end
        step();
        n_checks++;
        if (cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL release_run: got rst=%b expected 0", cpu_reset);
        end
        n_checks++;
        if (ram_out !== 4'h0) begin
            n_fail++;
            $display("FAIL release_bus_ignored: got ram_out=%h expected 0", ram_out);
        end
        bus_in = 8'h30;
    endtask

    task automatic test_read();
        bus_read(7'h03);
        step();
        n_checks++;
        if (ram_out !== 4'hF || data_out !== 2'b11) begin
            n_fail++;
            $display("FAIL read_hold: got %h/%b expected F/11", ram_out, data_out);
        end
        for (int a = 0; a < 3; a++) begin
            bus_read(7'(a));
        end
    endtask

    task automatic test_write_read();
        bus_read(7'h0A);
        bus_in = 8'h17;
        model_mem[7'h0A] = 4'h7;
        step();
        bus_in = 8'h30;
        n_checks++;
        if (bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ram_err: got %b expected 0", bus_err);
        end
        bus_read(7'h0A);
    endtask

    task automatic test_out_latch();
        bus_read(7'h05);
        bus_in = 8'h2C;
        exp_out[23:20] = 4'hC;
        step();
        n_checks++;
        if (out_port !== exp_out) begin
            n_fail++;
            $display("FAIL latch5: got %h expected %h", out_port, exp_out);
        end
        bus_read(7'h0A);
        bus_in = 8'h23;
        exp_out[11:8] = 4'h3;
        step();
        n_checks++;
        if (out_port !== exp_out || bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL latch2: got %h err=%b expected %h err=0", out_port, bus_err, exp_out);
        end
        bus_read(7'h05);
    endtask

    task automatic test_errors();
        bus_in = 8'h30;
        step();
        bus_in = 8'h2B;
        step();
        n_checks++;
        if (bus_err !== 1'b1 || out_port !== exp_out) begin
            n_fail++;
            $display("FAIL err_no_addr: got err=%b out=%h expected 1 %h", bus_err, out_port, exp_out);
        end
        bus_in = 8'h19;
        step();
        bus_read(7'h0A);
        bus_read(7'h02);
        bus_in = 8'h01;
        step();
        bus_in = 8'h30;
        n_checks++;
        if (out_port !== exp_out) begin
            n_fail++;
            $display("FAIL err_both_low_latch: got %h expected %h", out_port, exp_out);
        end
        bus_read(7'h02);
        repeat (2) step();
        n_checks++;
        if (bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", bus_err);
        end
    endtask

    // Reads of channel 2 issued back to back after the input toggles.
    task automatic test_ext_sync();
        ext_in = 8'hF6;
        bus_read(7'h02);
        bus_read(7'h02);
        ext_settled = 8'hF6;
        bus_read(7'h02);
        bus_read(7'h03);
    endtask

    task automatic test_reload();
        bus_read(7'h03);
        bus_in  = 8'h19;
        load_en = 1'b1;
        model_mem[7'h03] = 4'h9;
        step();
        n_checks++;
        if (cpu_reset !== 1'b1 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_enter: got rst=%b rdy=%b expected 1 1", cpu_reset, load_ready);
        end
        bus_in = 8'h85;
        step();
        bus_in = 8'h2D;
        step();
        n_checks++;
        if (ram_out !== 4'hF || out_port !== exp_out) begin
            n_fail++;
            $display("FAIL reload_bus_ignored: got %h/%h expected F/%h", ram_out, out_port, exp_out);
        end
        load_en = 1'b0;
        bus_in  = 8'h30;
        repeat (3) step();
        n_checks++;
        if (cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_run: got rst=%b expected 0", cpu_reset);
        end
        bus_read(7'h03);
    endtask

    task automatic test_final_reset();
        reset_n = 1'b0;
        step();
        n_checks++;
        if ({bus_err, cpu_reset, load_ready, ram_out, data_out, out_port} !== {3'b010, 38'd0}) begin
            n_fail++;
            $display("FAIL final_reset: got err=%b rst=%b rdy=%b ram=%h data=%b out=%h expected 0 1 0 0 0 0",
                     bus_err, cpu_reset, load_ready, ram_out, data_out, out_port);
        end
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_release();
        test_read();
        test_write_read();
        test_out_latch();
        test_errors();
        test_ext_sync();
        test_reload();
        test_final_reset();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
